// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide over 32 cycles, with a one-cycle fast path for divide corner cases.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [4:0]  RdE,
  input  logic        FlushE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] ResultE,
  output logic [4:0]  RdOutE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [4:0]  rd_q;
  logic        done_q;
  logic [31:0] result_q;
  logic [4:0]  rdout_q;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    mag32 = neg ? (32'd0 - x) : x;
  endfunction

  logic        a_sgn_s, b_sgn_s, sa_s, sb_s, neg_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        div0_s, ovf_s, fast_s;
  logic [31:0] fast_res_s;

  assign a_sgn_s = (funct3E == 3'b001) || (funct3E == 3'b010) ||
                   (funct3E == 3'b100) || (funct3E == 3'b110);
  assign b_sgn_s = (funct3E == 3'b001) || (funct3E == 3'b100) || (funct3E == 3'b110);
  assign sa_s    = a_sgn_s & SrcAE[31];
  assign sb_s    = b_sgn_s & SrcBE[31];
  assign mag_a_s = mag32(SrcAE, sa_s);
  assign mag_b_s = mag32(SrcBE, sb_s);
  // Remainders follow the dividend sign; everything else follows the sign product.
  assign neg_s   = (funct3E[2] & funct3E[1]) ? sa_s : (sa_s ^ sb_s);
  assign div0_s  = funct3E[2] && (SrcBE == 32'd0);
  assign ovf_s   = funct3E[2] && !funct3E[0] &&
                   (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
  assign fast_s  = div0_s || ovf_s;

  // Fast-path result for divide-by-zero and signed overflow.
  always_comb begin
    fast_res_s = 32'd0;
    if (div0_s) begin
      fast_res_s = funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
    end else if (ovf_s) begin
      fast_res_s = funct3E[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      fast_res_s = 32'd0;
    end
  end

  logic [32:0] mul_sum_s;
  logic [32:0] div_top_s;
  logic [31:0] div_diff_s;
  logic        div_ge_s;
  logic [63:0] step_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s, final_s;

  assign mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign div_top_s  = acc_q[63:31];
  assign div_ge_s   = div_top_s >= {1'b0, opb_q};
  assign div_diff_s = div_top_s[31:0] - opb_q;

  // One radix-2 iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    step_s = acc_q;
    if (!op_q[2]) begin
      step_s = {mul_sum_s, acc_q[31:1]};
    end else if (div_ge_s) begin
      step_s = {div_diff_s, acc_q[30:0], 1'b1};
    end else begin
      step_s = {div_top_s[31:0], acc_q[30:0], 1'b0};
    end
  end

  assign prod_s = neg_q ? (64'd0 - step_s) : step_s;
  assign quot_s = neg_q ? (32'd0 - step_s[31:0]) : step_s[31:0];
  assign rem_s  = neg_q ? (32'd0 - step_s[63:32]) : step_s[63:32];

  // Select the architectural result once the last iteration completes.
  always_comb begin
    final_s = 32'd0;
    case (op_q)
      3'b000:                 final_s = prod_s[31:0];
      3'b001, 3'b010, 3'b011: final_s = prod_s[63:32];
      3'b100, 3'b101:         final_s = quot_s;
      3'b110, 3'b111:         final_s = rem_s;
      default:                final_s = 32'd0;
    endcase
  end

  // Control FSM with operand, accumulator and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      rd_q     <= 5'd0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      rdout_q  <= 5'd0;
    end else begin
      done_q <= 1'b0;
      if (FlushE) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (StartE) begin
              op_q  <= funct3E;
              opb_q <= mag_b_s;
              neg_q <= neg_s;
              rd_q  <= RdE;
              cnt_q <= 5'd0;
              acc_q <= {32'd0, mag_a_s};
              if (fast_s) begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                result_q <= fast_res_s;
                rdout_q  <= RdE;
              end else begin
                state_q <= S_RUN;
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_RUN: begin
            acc_q <= step_s;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= final_s;
              rdout_q  <= rd_q;
            end else begin
              state_q <= S_RUN;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign BusyE   = ((state_q == S_IDLE) && StartE && !FlushE) || (state_q == S_RUN);
  assign DoneE   = done_q;
  assign ResultE = result_q;
  assign RdOutE  = rdout_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized and directed bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset = 1'b0;
  logic        StartE = 1'b0;
  logic [2:0]  funct3E = 3'd0;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic [4:0]  RdE = 5'd0;
  logic        FlushE = 1'b0;
  logic        BusyE, DoneE;
  logic [31:0] ResultE;
  logic [4:0]  RdOutE;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_res = 32'd0;

  ex_muldiv_unit dut (
    .clk(clk), .reset(reset), .StartE(StartE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE), .FlushE(FlushE),
    .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE), .RdOutE(RdOutE)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib, iq;
    longint sa, sb, ua, ub;
    logic [63:0] p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    ref_result = 32'd0;
    case (op)
      3'd0: begin p = ua * ub; ref_result = p[31:0]; end
      3'd1: begin p = sa * sb; ref_result = p[63:32]; end
      3'd2: begin p = sa * ub; ref_result = p[63:32]; end
      3'd3: begin p = ua * ub; ref_result = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) ref_result = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h8000_0000;
        else begin iq = ia / ib; ref_result = iq; end
      end
      3'd5: ref_result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) ref_result = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'd0;
        else begin iq = ia % ib; ref_result = iq; end
      end
      default: ref_result = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      ref_latency = 1;
    else
      ref_latency = 33;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp;
    int lat, k;
    bit seen;
    exp = ref_result(op, a, b);
    lat = ref_latency(op, a, b);
    @(negedge clk);
    StartE = 1'b1; funct3E = op; SrcAE = a; SrcBE = b; RdE = rd;
    #1 check_eq("busy_on_start", BusyE, 1);
    @(posedge clk);
    k = 0; seen = 0;
    while (!seen && k < 60) begin
      @(negedge clk);
      StartE = 1'b0;
      k++;
      if (DoneE) seen = 1;
      else if (k == 2 && lat == 33) check_eq("busy_in_run", BusyE, 1);
    end
    check_eq($sformatf("latency op%0d", op), k, lat);
    if (seen) begin
      check_eq($sformatf("result op%0d a=%h b=%h", op, a, b), ResultE, exp);
      check_eq("rdout", RdOutE, rd);
      check_eq("busy_in_done", BusyE, 0);
      @(negedge clk);
      check_eq("done_one_cycle", DoneE, 0);
      @(negedge clk);
      check_eq("result_hold", ResultE, exp);
      last_res = exp;
    end
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (DoneE) hits++;
    end
    check_eq(tag, hits, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int sel;

    #12;
    check_eq("rst_busy", BusyE, 0);
    check_eq("rst_done", DoneE, 0);
    check_eq("rst_result", ResultE, 0);
    check_eq("rst_rdout", RdOutE, 0);
    @(negedge clk);
    reset = 1'b1;
    StartE = 1'b1; funct3E = 3'd0; SrcAE = 32'd7; SrcBE = 32'hFFFF_FFFD; RdE = 5'd1;
    @(posedge clk);
    #1 check_eq("accept_first_edge", BusyE, 1);
    for (int i = 0; i < 33; i++) @(negedge clk);
    StartE = 1'b0;
    check_eq("first_edge_done", DoneE, 1);
    check_eq("first_edge_result", ResultE, 32'hFFFF_FFEB);
    @(negedge clk);

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd2);
    run_op(3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3);
    run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 5'd4);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run_op(3'd5, 32'd100, 32'd7, 5'd8);
    run_op(3'd7, 32'd100, 32'd7, 5'd9);
    run_op(3'd5, 32'h0000_1234, 32'd0, 5'd10);
    run_op(3'd7, 32'h0000_1234, 32'd0, 5'd11);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    run_op(3'd4, 32'h8000_0000, 32'd0, 5'd14);

    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      run_op(op, a, b, 5'($urandom_range(1, 31)));
    end

    // Flush mid-run: aborted op produces no strobe and no result change.
    @(negedge clk);
    StartE = 1'b1; funct3E = 3'd3; SrcAE = 32'hDEAD_BEEF; SrcBE = 32'h1234_5678; RdE = 5'd20;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin @(negedge clk); StartE = 1'b0; end
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    check_eq("flush_idle_busy", BusyE, 0);
    expect_no_done("flush_no_done", 40);
    check_eq("flush_result_hold", ResultE, last_res);
    run_op(3'd5, 32'd1000, 32'd9, 5'd21);

    // Start and flush together in idle: not accepted.
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; funct3E = 3'd0; SrcAE = 32'd3; SrcBE = 32'd3; RdE = 5'd22;
    #1 check_eq("start_flush_busy", BusyE, 0);
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
    check_eq("start_flush_idle", BusyE, 0);
    expect_no_done("start_flush_no_done", 40);

    // Second start during run is ignored.
    @(negedge clk);
    StartE = 1'b1; funct3E = 3'd5; SrcAE = 32'd500; SrcBE = 32'd7; RdE = 5'd3;
    @(posedge clk);
    for (int i = 0; i < 4; i++) @(negedge clk);
    funct3E = 3'd0; SrcAE = 32'd9; SrcBE = 32'd9; RdE = 5'd9;
    @(negedge clk);
    StartE = 1'b0;
    for (int i = 0; i < 28; i++) @(negedge clk);
    check_eq("ignore_start_done", DoneE, 1);
    check_eq("ignore_start_result", ResultE, 32'd71);
    check_eq("ignore_start_rd", RdOutE, 3);
    @(negedge clk);

    // Asynchronous reset mid-run with the clock stopped.
    @(negedge clk);
    StartE = 1'b1; funct3E = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd3; RdE = 5'd17;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin @(negedge clk); StartE = 1'b0; end
    clk_en = 1'b0;
    #7 reset = 1'b0;
    #1;
    check_eq("async_rst_busy", BusyE, 0);
    check_eq("async_rst_done", DoneE, 0);
    check_eq("async_rst_result", ResultE, 0);
    check_eq("async_rst_rdout", RdOutE, 0);
    #10 reset = 1'b1;
    #3 clk_en = 1'b1;
    expect_no_done("rst_discard_no_done", 40);
    check_eq("rst_discard_idle", BusyE, 0);
    run_op(3'd6, 32'hFFFF_FF00, 32'd7, 5'd30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
